// File: rtl/pmod_link_pkg.sv
// Shared definitions for the PMOD move link (transmitter and receiver).
// State codes, default sizing and a counter-width helper.
package pmod_link_pkg;

  localparam int DATA_W_DEF      = 16;
  localparam int CLK_DIV_DEF     = 50;
  localparam int ACK_TIMEOUT_DEF = 100000;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_SHIFT_LO  = 3'd1;
  localparam state_t ST_SHIFT_HI  = 3'd2;
  localparam state_t ST_PARITY_LO = 3'd3;
  localparam state_t ST_PARITY_HI = 3'd4;
  localparam state_t ST_WAIT_ACK  = 3'd5;
  localparam state_t ST_DONE      = 3'd6;
  localparam state_t ST_ERR       = 3'd7;

  // Bits needed for a counter that takes n distinct values.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pmod_sync_edge.sv
// Two-flop synchronizer with rising-edge detect for an async PMOD line.
// clr discards any edge in flight (used when a new wait window opens).
module pmod_sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  input  logic clr,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= clr ? 1'b1 : s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/pmod_move_tx.sv
// Source-clocked PMOD move transmitter, MSB first, with ack handshake.
// Optional even parity bit enabled by defining PMOD_TX_PARITY_EN.
module pmod_move_tx
  import pmod_link_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int CLK_DIV     = CLK_DIV_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              pmod_clk,
  output logic              pmod_data,
  output logic              pmod_frame,
  input  logic              pmod_ack,
  output logic              done,
  output logic              err
);

  localparam int DW = cnt_w(CLK_DIV);
  localparam int BW = cnt_w(DATA_W);
  localparam int TW = cnt_w(ACK_TIMEOUT);

  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(DATA_W - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(ACK_TIMEOUT - 1);

  state_t            state, state_nx;
  logic [DATA_W-1:0] shreg;
  logic [BW-1:0]     bit_cnt;
  logic [DW-1:0]     div_cnt;
  logic [TW-1:0]     to_cnt;
  logic              take, div_end, last_bit;
  logic              shifting, ack_rise, ack_clr;
`ifdef PMOD_TX_PARITY_EN
  logic              par_q;
`endif

  assign take     = tx_valid & tx_ready;
  assign div_end  = (div_cnt == DIV_MAX);
  assign last_bit = (bit_cnt == '0);
  assign shifting = (state == ST_SHIFT_LO) |
                    (state == ST_SHIFT_HI) |
                    (state == ST_PARITY_LO) |
                    (state == ST_PARITY_HI);
  assign ack_clr  = (state != ST_WAIT_ACK) &
                    (state_nx == ST_WAIT_ACK);

  pmod_sync_edge u_ack (
    .clock    (clock),
    .reset    (reset),
    .async_in (pmod_ack),
    .clr      (ack_clr),
    .rise     (ack_rise)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:     if (take) state_nx = ST_SHIFT_LO;
      ST_SHIFT_LO: if (div_end) state_nx = ST_SHIFT_HI;
      ST_SHIFT_HI: begin
        if (div_end) begin
          if (!last_bit) state_nx = ST_SHIFT_LO;
`ifdef PMOD_TX_PARITY_EN
          else state_nx = ST_PARITY_LO;
`else
          else state_nx = ST_WAIT_ACK;
`endif
        end
      end
`ifdef PMOD_TX_PARITY_EN
      ST_PARITY_LO: if (div_end) state_nx = ST_PARITY_HI;
      ST_PARITY_HI: if (div_end) state_nx = ST_WAIT_ACK;
`endif
      // An edge coinciding with the timeout wins.
      ST_WAIT_ACK: begin
        if (ack_rise)             state_nx = ST_DONE;
        else if (to_cnt == TO_MAX) state_nx = ST_ERR;
      end
      ST_DONE: state_nx = ST_IDLE;
      ST_ERR:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      to_cnt  <= '0;
`ifdef PMOD_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      if (take) begin
        shreg   <= tx_data;
        bit_cnt <= BIT_MAX;
`ifdef PMOD_TX_PARITY_EN
        par_q   <= ^tx_data;
`endif
      end else if ((state == ST_SHIFT_HI) && div_end && !last_bit) begin
        shreg   <= shreg << 1;
        bit_cnt <= bit_cnt - 1'b1;
      end
      if (shifting) div_cnt <= div_end ? '0 : div_cnt + 1'b1;
      else          div_cnt <= '0;
      if (state == ST_WAIT_ACK) to_cnt <= to_cnt + 1'b1;
      else                      to_cnt <= '0;
    end
  end

  always_comb begin
    tx_ready   = 1'b0;
    pmod_clk   = 1'b0;
    pmod_data  = 1'b0;
    pmod_frame = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    unique case (state)
      ST_IDLE: tx_ready = 1'b1;
      ST_SHIFT_LO: begin
        pmod_frame = 1'b1;
        pmod_data  = shreg[DATA_W-1];
      end
      ST_SHIFT_HI: begin
        pmod_frame = 1'b1;
        pmod_clk   = 1'b1;
        pmod_data  = shreg[DATA_W-1];
      end
`ifdef PMOD_TX_PARITY_EN
      ST_PARITY_LO: begin
        pmod_frame = 1'b1;
        pmod_data  = par_q;
      end
      ST_PARITY_HI: begin
        pmod_frame = 1'b1;
        pmod_clk   = 1'b1;
        pmod_data  = par_q;
      end
`endif
      ST_DONE: done = 1'b1;
      ST_ERR:  err  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pmod_move_tx.sv
// Scoreboard bench for pmod_move_tx (DATA_W=16, CLK_DIV=4, ACK_TIMEOUT=64).
// Stimulus pushes expected frames; a negedge monitor pops on done/err.
module tb_pmod_move_tx;

`ifdef PMOD_TX_PARITY_EN
  localparam int NB = 17;
`else
  localparam int NB = 16;
`endif
  localparam int FL = NB * 8;

  typedef struct packed {
    logic [31:0] bits;
    logic        ok;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        tx_valid;
  logic [15:0] tx_data;
  logic        tx_ready;
  logic        pmod_clk;
  logic        pmod_data;
  logic        pmod_frame;
  logic        pmod_ack;
  logic        done;
  logic        err;

  logic ack_auto, ack_spur, ack_en;
  assign pmod_ack = ack_auto | ack_spur;

  exp_t q[$];
  int   n_tests, n_fail;
  int   n_done, n_done_exp;

  pmod_move_tx #(
    .DATA_W      (16),
    .CLK_DIV     (4),
    .ACK_TIMEOUT (64)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .pmod_clk   (pmod_clk),
    .pmod_data  (pmod_data),
    .pmod_frame (pmod_frame),
    .pmod_ack   (pmod_ack),
    .done       (done),
    .err        (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  logic [63:0] m_bits;
  int          m_nb, m_flen, m_wcnt;
  logic        m_prev_clk, m_prev_frame;
  exp_t        m_e;

  always @(negedge clock) begin
    if (!reset) begin
      m_prev_clk   = 1'b0;
      m_prev_frame = 1'b0;
      m_bits = '0;
      m_nb   = 0;
      m_flen = 0;
      m_wcnt = 0;
    end else begin
      if (pmod_frame) begin
        if (!m_prev_frame) begin
          m_bits = '0;
          m_nb   = 0;
          m_flen = 0;
        end
        m_flen++;
        if (pmod_clk && !m_prev_clk) begin
          m_bits = {m_bits[62:0], pmod_data};
          m_nb++;
        end
      end else begin
        if (m_prev_frame) m_wcnt = 0;
        else              m_wcnt++;
      end
      if (done || err) begin
        if (done) n_done++;
        if (q.size() == 0) begin
          chk("unexpected_pulse", {62'd0, done, err}, 64'd0);
        end else begin
          m_e = q.pop_front();
          chk("outcome", {62'd0, done, err},
              m_e.ok ? 64'd2 : 64'd1);
          chk("data", m_bits & ((64'd1 << NB) - 1),
              {32'd0, m_e.bits});
          chk("nbits", 64'(m_nb), 64'(NB));
          chk("frame_len", 64'(m_flen), 64'(FL));
          if (!m_e.ok) chk("ack_timeout", 64'(m_wcnt), 64'd64);
        end
      end
      m_prev_clk   = pmod_clk;
      m_prev_frame = pmod_frame;
    end
  end

  // Receiver ack model: raise ack 10 clocks after the frame falls
  logic r_prev;
  initial begin
    r_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (reset && ack_en && r_prev && !pmod_frame) begin
        repeat (10) @(posedge clock);
        #1 ack_auto = 1'b1;
        repeat (4) @(posedge clock);
        #1 ack_auto = 1'b0;
      end
      r_prev = pmod_frame;
    end
  end

  function automatic logic [31:0] exp_bits(input logic [15:0] d);
`ifdef PMOD_TX_PARITY_EN
    return {15'd0, d, ^d};
`else
    return {16'd0, d};
`endif
  endfunction

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 2000; k++) begin
      @(negedge clock);
      if (tx_ready && q.size() == 0) break;
    end
    chk(name, {63'd0, (k < 2000)}, 64'd1);
  endtask

  task automatic send(input logic [15:0] d,
                      input logic ok,
                      input logic push);
    exp_t e;
    wait_idle("idle_before_send");
    @(negedge clock);
    tx_valid = 1'b1;
    tx_data  = d;
    if (push) begin
      e.bits = exp_bits(d);
      e.ok   = ok;
      q.push_back(e);
      if (ok) n_done_exp++;
    end
    @(posedge clock);
    #1 tx_valid = 1'b0;
    tx_data = 16'($urandom);
  endtask

  initial begin
    exp_t e;
    int   k;
    n_tests = 0; n_fail = 0;
    n_done = 0;  n_done_exp = 0;
    reset = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    ack_auto = 1'b0;
    ack_spur = 1'b0;
    ack_en   = 1'b1;

    repeat (2) @(negedge clock);
    chk("reset_outs",
        {58'd0, tx_ready, pmod_clk, pmod_data,
         pmod_frame, done, err}, 64'h20);
    reset = 1'b1;

    // basic send
    send(16'hA5C3, 1'b1, 1'b1);
    @(negedge clock);
    chk("busy_after_take", {63'd0, tx_ready}, 64'd0);
    wait_idle("basic_ready");

    // ack timeout
    ack_en = 1'b0;
    send(16'h0001, 1'b0, 1'b1);
    wait_idle("timeout_ready");
    ack_en = 1'b1;

    // back-pressure: valid held, data churning
    wait_idle("bp_idle");
    @(negedge clock);
    tx_valid = 1'b1;
    tx_data  = 16'h1234;
    e.bits = exp_bits(16'h1234);
    e.ok   = 1'b1;
    q.push_back(e);
    n_done_exp++;
    for (k = 0; k < 2000; k++) begin
      @(negedge clock);
      if (tx_ready) break;
      tx_data = 16'($urandom);
    end
    chk("bp_order", 64'(q.size()), 64'd0);
    tx_data = 16'h5A5A;
    e.bits = exp_bits(16'h5A5A);
    q.push_back(e);
    n_done_exp++;
    @(posedge clock);
    #1 tx_valid = 1'b0;
    wait_idle("bp_ready");

    // async reset mid-frame
    send(16'h0F0F, 1'b1, 1'b0);
    repeat (42) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("abort_outs",
        {58'd0, tx_ready, pmod_clk, pmod_data,
         pmod_frame, done, err}, 64'h20);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    send(16'hFFFF, 1'b1, 1'b1);
    wait_idle("after_reset_ready");

    // spurious ack during shift
    send(16'h8001, 1'b1, 1'b1);
    repeat (20) @(posedge clock);
    #1 ack_spur = 1'b1;
    repeat (3) @(posedge clock);
    #1 ack_spur = 1'b0;
    repeat (30) @(posedge clock);
    #1 ack_spur = 1'b1;
    repeat (2) @(posedge clock);
    #1 ack_spur = 1'b0;
    wait_idle("spur_ready");

    // parity-sensitive vector
    send(16'h0007, 1'b1, 1'b1);
    wait_idle("final_ready");

    repeat (20) @(negedge clock);
    chk("queue_empty", 64'(q.size()), 64'd0);
    chk("done_count", 64'(n_done), 64'(n_done_exp));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
